// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO: rising-edge send requests queue
// characters that go out back-to-back as start/data/parity/stop frames.
module uart_tx_fifo #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 1,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow
);

  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int BAUD_W      = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CLOCKS - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Odd mode makes the total count of ones (data + parity) odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    if (PARITY_MODE == 1) return ~^d;
    else                  return ^d;
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 send_q, req, wr_en, pop;

  state_t               state, state_d;
  logic [BAUD_W-1:0]    baud_cnt, baud_d;
  logic [3:0]           bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_bit, par_d, tx_d;

  assign req   = send & ~send_q;
  assign full  = (count == DEPTH_CNT);
  assign wr_en = req & ~full;
  assign busy  = (count != '0) | (state != IDLE);

  // full is taken from the registered count, so a pop in the same cycle
  // never frees room for a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      send_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      send_q   <= send;
      overflow <= req & full;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    par_d   = par_bit;
    tx_d    = tx_out;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              tx_d    = par_bit;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_cnt + 1'b1;
            tx_d    = shreg[0];
            shreg_d = shreg >> 1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when more is queued.
            if (count != '0) begin
              pop     = 1'b1;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      shreg_d = mem[rd_ptr];
      par_d   = parity_of(mem[rd_ptr]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_out   <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      tx_out   <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg   <= shreg_d;
    par_bit <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line waveforms and received characters
// are compared against a frame model built from the UART framing rules.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLKF = 307_205;
  localparam int BAUD = 19_200;
  localparam int BC   = CLKF / BAUD;
  localparam int F8   = (1 + 8 + 1 + 1) * BC;
  localparam int F7   = (1 + 7 + 1 + 2) * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       send = 1'b0, send7 = 1'b0;
  logic [7:0] din = '0;
  logic [6:0] din7 = '0;
  logic       tx_out, busy, full, overflow;
  logic       tx7, busy7, full7, ovf7;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic smp [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst(rst), .send(send), .din(din),
    .tx_out(tx_out), .busy(busy), .full(full), .overflow(overflow));

  uart_tx_fifo #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7),
                 .PARITY_MODE(2), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .send(send7), .din(din7),
    .tx_out(tx7), .busy(busy7), .full(full7), .overflow(ovf7));

  // Reference frame: bit k is the k-th line bit (start, data LSB first, parity, stops).
  function automatic logic [15:0] exp_frame(input logic [8:0] d, input int nbits,
                                            input int pmode, input int nstop);
    logic [15:0] f;
    int ones, k;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    k = 1 + nbits;
    if (pmode == 1) f[k] = ((ones % 2) == 0);
    else if (pmode == 2) f[k] = ((ones % 2) == 1);
    return f;
  endfunction

  function automatic int wave_bad(input logic [15:0] ef, input int flen);
    int n = 0;
    for (int t = 0; t < flen; t++) if (smp[t] !== ef[t/BC]) n++;
    return n;
  endfunction

  // Receiver model: sample each data bit in the middle of its bit period.
  function automatic logic [8:0] rx_decode(input int nbits);
    logic [8:0] d = '0;
    for (int i = 0; i < nbits; i++) d[i] = smp[(1+i)*BC + BC/2];
    return d;
  endfunction

  task automatic rx_frame(input bit use7, input int flen, output int start_cyc,
                          output logic busy_last, output bit timeout);
    int waited = 0;
    timeout = 1'b0;
    start_cyc = -1;
    busy_last = 1'b0;
    while (1) begin
      @(negedge clk);
      if ((use7 ? tx7 : tx_out) === 1'b0) break;
      waited++;
      if (waited > 2000) begin
        timeout = 1'b1;
        return;
      end
    end
    start_cyc = cyc;
    smp[0] = 1'b0;
    for (int t = 1; t < flen; t++) begin
      @(negedge clk);
      smp[t] = use7 ? tx7 : tx_out;
    end
    busy_last = use7 ? busy7 : busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    send = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({tx_out, busy, full, overflow, tx7, busy7, full7, ovf7} !== 8'b1000_1000) begin
      errors++;
      $display("FAIL reset_async got=%b exp=10001000", {tx_out, busy, full, overflow, tx7, busy7, full7, ovf7});
    end
    repeat (8) @(negedge clk);
    checks++;
    if ({tx_out, busy, full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=1000", {tx_out, busy, full, overflow});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_out, busy, full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release_send_held got=%b exp=1000", {tx_out, busy, full, overflow});
    end
    send = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int nreq, st, nb;
    logic bl;
    bit to;
    @(negedge clk);
    send = 1'b1;
    din = 8'hA5;
    @(negedge clk);
    nreq = cyc;
    send = 1'b0;
    checks++;
    if ({busy, tx_out, full} !== 3'b110) begin
      errors++;
      $display("FAIL single_latency got=%b exp=110", {busy, tx_out, full});
    end
    rx_frame(1'b0, F8, st, bl, to);
    checks++;
    if (to || st != nreq + 1) begin
      errors++;
      $display("FAIL single_start got=%0d exp=%0d", st, nreq + 1);
    end
    checks++;
    if (rx_decode(8) !== 9'h0A5) begin
      errors++;
      $display("FAIL single_data got=%h exp=0a5", rx_decode(8));
    end
    nb = wave_bad(exp_frame(9'h0A5, 8, 1, 1), F8);
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL single_wave got=%0d bad cycles exp=0", nb);
    end
    @(negedge clk);
    checks++;
    if ({bl, busy, tx_out} !== 3'b101) begin
      errors++;
      $display("FAIL single_busy_fall got=%b exp=101", {bl, busy, tx_out});
    end
  endtask

  task automatic test_burst;
    logic [7:0] d [6];
    d = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h7E};
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          send = 1'b1;
          din = d[k];
          if (k == 5) begin
            checks++;
            if (full !== 1'b1) begin
              errors++;
              $display("FAIL burst_full got=%b exp=1", full);
            end
          end
          @(negedge clk);
          send = 1'b0;
          checks++;
          if (overflow !== (k == 5)) begin
            errors++;
            $display("FAIL burst_ovf%0d got=%b exp=%b", k, overflow, (k == 5));
          end
          @(negedge clk);
          checks++;
          if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_ovf_width%0d got=%b exp=0", k, overflow);
          end
          @(negedge clk);
        end
      end
      begin
        int st, prev, nb, lows;
        logic bl;
        bit to;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
          rx_frame(1'b0, F8, st, bl, to);
          checks++;
          if (to || rx_decode(8) !== {1'b0, d[k]}) begin
            errors++;
            $display("FAIL burst_data%0d got=%h exp=%h", k, rx_decode(8), d[k]);
          end
          nb = wave_bad(exp_frame({1'b0, d[k]}, 8, 1, 1), F8);
          checks++;
          if (nb != 0) begin
            errors++;
            $display("FAIL burst_wave%0d got=%0d bad cycles exp=0", k, nb);
          end
          if (k > 0) begin
            checks++;
            if (st != prev + F8) begin
              errors++;
              $display("FAIL burst_gap%0d got=%0d exp=%0d", k, st, prev + F8);
            end
          end
          prev = st;
        end
        @(negedge clk);
        checks++;
        if ({bl, busy} !== 2'b10) begin
          errors++;
          $display("FAIL burst_busy_fall got=%b exp=10", {bl, busy});
        end
        lows = 0;
        repeat (2 * F8) begin
          @(negedge clk);
          if (tx_out !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
          errors++;
          $display("FAIL burst_extra_frame got=%0d low cycles exp=0", lows);
        end
      end
    join
  endtask

  task automatic test_config7;
    int nreq, st, nb;
    logic bl;
    bit to;
    @(negedge clk);
    send7 = 1'b1;
    din7 = 7'h7F;
    @(negedge clk);
    nreq = cyc;
    send7 = 1'b0;
    rx_frame(1'b1, F7, st, bl, to);
    checks++;
    if (to || st != nreq + 1 || rx_decode(7) !== 9'h07F) begin
      errors++;
      $display("FAIL cfg7_data got=%h start=%0d exp=07f start=%0d", rx_decode(7), st, nreq + 1);
    end
    nb = wave_bad(exp_frame(9'h07F, 7, 2, 2), F7);
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL cfg7_wave got=%0d bad cycles exp=0", nb);
    end
    @(negedge clk);
    checks++;
    if ({bl, busy7, tx7} !== 3'b101) begin
      errors++;
      $display("FAIL cfg7_busy_fall got=%b exp=101", {bl, busy7, tx7});
    end
  endtask

  task automatic test_reset_mid;
    int st, nreq, lows, nb;
    logic bl;
    bit to;
    @(negedge clk);
    send = 1'b1;
    din = 8'hA5;
    @(negedge clk);
    send = 1'b0;
    @(negedge clk);
    st = cyc;
    send = 1'b1;
    din = 8'h3C;
    @(negedge clk);
    send = 1'b0;
    while (cyc < st + 4 * BC) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_line_before got=%b exp=0", tx_out);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({tx_out, busy, full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_async got=%b exp=1000", {tx_out, busy, full, overflow});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_after got=%b exp=0", busy);
    end
    lows = 0;
    repeat (F8 + 2 * BC) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL mid_discarded got=%0d low cycles exp=0", lows);
    end
    @(negedge clk);
    send = 1'b1;
    din = 8'h5A;
    @(negedge clk);
    nreq = cyc;
    send = 1'b0;
    rx_frame(1'b0, F8, st, bl, to);
    checks++;
    if (to || st != nreq + 1 || rx_decode(8) !== 9'h05A) begin
      errors++;
      $display("FAIL mid_fresh got=%h start=%0d exp=05a start=%0d", rx_decode(8), st, nreq + 1);
    end
    nb = wave_bad(exp_frame(9'h05A, 8, 1, 1), F8);
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL mid_fresh_wave got=%0d bad cycles exp=0", nb);
    end
    @(negedge clk);
  endtask

  task automatic test_held;
    fork
      begin
        @(negedge clk);
        send = 1'b1;
        din = 8'h42;
        repeat (100) @(negedge clk);
        send = 1'b0;
      end
      begin
        int st;
        logic bl;
        bit to;
        rx_frame(1'b0, F8, st, bl, to);
        checks++;
        if (to || rx_decode(8) !== 9'h042) begin
          errors++;
          $display("FAIL held_data got=%h exp=042", rx_decode(8));
        end
      end
    join
    begin
      int lows = 0;
      repeat (2 * F8) begin
        @(negedge clk);
        if (tx_out !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL held_single got=%0d low cycles busy=%b exp=0 busy=0", lows, busy);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      logic [7:0] b [7];
      int k, exp_n, exp_ovf, ovf_cnt;
      k = $urandom_range(1, 7);
      exp_n = (k > 5) ? 5 : k;
      exp_ovf = (k > 5) ? k - 5 : 0;
      for (int j = 0; j < 7; j++) b[j] = 8'($urandom);
      ovf_cnt = 0;
      fork
        begin
          for (int j = 0; j < k; j++) begin
            @(negedge clk);
            send = 1'b1;
            din = b[j];
            @(negedge clk);
            send = 1'b0;
            if (overflow === 1'b1) ovf_cnt++;
            repeat ($urandom_range(0, 2)) begin
              @(negedge clk);
              if (overflow === 1'b1) ovf_cnt++;
            end
          end
          repeat (3) begin
            @(negedge clk);
            if (overflow === 1'b1) ovf_cnt++;
          end
        end
        begin
          int st, nb;
          logic bl;
          bit to;
          for (int j = 0; j < exp_n; j++) begin
            rx_frame(1'b0, F8, st, bl, to);
            nb = wave_bad(exp_frame({1'b0, b[j]}, 8, 1, 1), F8);
            checks++;
            if (to || rx_decode(8) !== {1'b0, b[j]} || nb != 0) begin
              errors++;
              $display("FAIL rand%0d_frame%0d got=%h bad=%0d exp=%h bad=0", it, j, rx_decode(8), nb, b[j]);
            end
          end
          @(negedge clk);
          checks++;
          if ({bl, busy} !== 2'b10) begin
            errors++;
            $display("FAIL rand%0d_busy_fall got=%b exp=10", it, {bl, busy});
          end
        end
      join
      checks++;
      if (ovf_cnt != exp_ovf) begin
        errors++;
        $display("FAIL rand%0d_overflow got=%0d exp=%0d", it, ovf_cnt, exp_ovf);
      end
      begin
        int lows = 0;
        repeat (F8 + BC) begin
          @(negedge clk);
          if (tx_out !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
          errors++;
          $display("FAIL rand%0d_extra got=%0d low cycles exp=0", it, lows);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_config7;
    test_reset_mid;
    test_held;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
